// File: rtl/m_lfsr_seq_ctrl_pkg.sv
// rtl/m_lfsr_seq_ctrl_pkg.sv - sequencer state type, default widths and word packing helper
package m_lfsr_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_SEND = 2'd3
  } seq_state_t;

  localparam int DEF_LFSR_W = 32;
  localparam int DEF_OUT_W  = 32;
  localparam int DEF_CNT_W  = 32;

  // Value of word bit 'pos' after the serial bit lands at index 'idx' (LSB-first packing).
  function automatic logic lsb_first_insert(input logic cur_bit, input logic new_bit,
                                            input int pos, input int idx);
    return (pos == idx) ? new_bit : cur_bit;
  endfunction

endpackage

// File: rtl/m_lfsr_seq_packer.sv
// rtl/m_lfsr_seq_packer.sv - OUT_W-bit LSB-first serial-to-parallel packer with bit counter
module m_lfsr_seq_packer
  import m_lfsr_seq_ctrl_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic             full,
  output logic [OUT_W-1:0] word
);

  localparam int CW = $clog2(OUT_W);

  logic [CW-1:0]    bit_cnt;
  logic [31:0]      idx_i;
  logic [OUT_W-1:0] word_nxt;

  // full marks the shift that completes the word, so the caller can leave FILL on this edge
  assign full  = shift_en & (bit_cnt == CW'(OUT_W - 1));
  assign idx_i = {{(32 - CW){1'b0}}, bit_cnt};

  always_comb begin
    word_nxt = word;
    for (int i = 0; i < OUT_W; i++) begin
      word_nxt[i] = lsb_first_insert(word[i], bit_in, i, idx_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_cnt <= '0;
      word    <= '0;
    end else if (shift_en) begin
      word    <= word_nxt;
      bit_cnt <= full ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/m_lfsr_seq_ctrl.sv
// rtl/m_lfsr_seq_ctrl.sv - LFSR load/step sequencer and word streamer; irq generated only with M_LFSR_SEQ_CTRL_IRQ_EN
module m_lfsr_seq_ctrl
  import m_lfsr_seq_ctrl_pkg::*;
#(
  parameter int LFSR_W = DEF_LFSR_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_continuous,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic [LFSR_W-1:0] cfg_taps,
  input  logic [CNT_W-1:0]  cfg_words,
  output logic              stat_busy,
  output logic              stat_done,
  output logic              stat_err,
  output logic [CNT_W-1:0]  stat_words_sent,
  output logic              irq,
  output logic              lfsr_load,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic [LFSR_W-1:0] lfsr_taps,
  output logic              lfsr_step,
  input  logic              lfsr_bit,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  seq_state_t        state, state_nxt;
  logic [LFSR_W-1:0] seed_q, taps_q;
  logic [CNT_W-1:0]  words_q, words_sent;
  logic              cont_q, abort_q, done_q, err_q;
  logic              start_acc, cfg_bad, last_nat, run_end;
  logic              fill_shift, pack_clear, pack_full, send_hs;

  // Abort outranks start in IDLE, so a simultaneous pair does nothing.
  assign start_acc  = (state == ST_IDLE) & cfg_start & ~cfg_abort;
  assign cfg_bad    = (cfg_seed == '0) | ((cfg_words == '0) & ~cfg_continuous);
  assign last_nat   = ~cont_q & ((words_sent + CNT_W'(1)) == words_q);
  assign fill_shift = (state == ST_FILL);
  assign pack_clear = (state == ST_LOAD) | (fill_shift & cfg_abort);
  assign send_hs    = (state == ST_SEND) & m_axis_tready;

  m_lfsr_seq_packer #(
    .OUT_W(OUT_W)
  ) u_packer (
    .clk     (ACLK),
    .rst     (ARESET),
    .clear   (pack_clear),
    .shift_en(fill_shift),
    .bit_in  (lfsr_bit),
    .full    (pack_full),
    .word    (m_axis_tdata)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    run_end       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_acc && !cfg_bad) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        lfsr_load = 1'b1;
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
          run_end   = 1'b1;
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        lfsr_step = 1'b1;
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
          run_end   = 1'b1;
        end else if (pack_full) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // An abort seen now or earlier in this word turns it into the final word.
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = abort_q | cfg_abort | last_nat;
        if (m_axis_tready) begin
          if (abort_q || cfg_abort || last_nat) begin
            state_nxt = ST_IDLE;
            run_end   = 1'b1;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      seed_q     <= '0;
      taps_q     <= '0;
      words_q    <= '0;
      cont_q     <= 1'b0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_sent <= '0;
    end else begin
      if (start_acc) begin
        seed_q  <= cfg_seed;
        taps_q  <= cfg_taps;
        words_q <= cfg_words;
        cont_q  <= cfg_continuous;
        abort_q <= 1'b0;
        if (cfg_bad) begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end else begin
          err_q      <= 1'b0;
          done_q     <= 1'b0;
          words_sent <= '0;
        end
      end
      if ((state == ST_SEND) && cfg_abort) abort_q <= 1'b1;
      if (send_hs) words_sent <= words_sent + CNT_W'(1);
      if (run_end) done_q <= 1'b1;
    end
  end

`ifdef M_LFSR_SEQ_CTRL_IRQ_EN
  logic irq_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) irq_q <= 1'b0;
    else        irq_q <= run_end | (start_acc & cfg_bad);
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign stat_busy       = (state != ST_IDLE);
  assign stat_done       = done_q;
  assign stat_err        = err_q;
  assign stat_words_sent = words_sent;
  assign lfsr_seed       = seed_q;
  assign lfsr_taps       = taps_q;

endmodule

// File: tb/tb_m_lfsr_seq_ctrl.sv
// tb/tb_m_lfsr_seq_ctrl.sv - self-checking bench for m_lfsr_seq_ctrl with LFSR core and stream reference models
module tb_m_lfsr_seq_ctrl;

  localparam int LW = 32;
  localparam int OW = 32;
  localparam int CW = 4;
`ifdef M_LFSR_SEQ_CTRL_IRQ_EN
  localparam int IRQ_PER = 1;
`else
  localparam int IRQ_PER = 0;
`endif

  logic          ACLK = 1'b0, ARESET = 1'b1;
  logic          cfg_start = 1'b0, cfg_abort = 1'b0, cfg_continuous = 1'b0;
  logic [LW-1:0] cfg_seed = '0, cfg_taps = '0;
  logic [CW-1:0] cfg_words = '0;
  logic          stat_busy, stat_done, stat_err, irq;
  logic [CW-1:0] stat_words_sent;
  logic          lfsr_load, lfsr_step, lfsr_bit;
  logic [LW-1:0] lfsr_seed, lfsr_taps;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  m_lfsr_seq_ctrl #(.LFSR_W(LW), .OUT_W(OW), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_continuous(cfg_continuous),
    .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_words(cfg_words),
    .stat_busy(stat_busy), .stat_done(stat_done), .stat_err(stat_err),
    .stat_words_sent(stat_words_sent), .irq(irq),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_taps(lfsr_taps),
    .lfsr_step(lfsr_step), .lfsr_bit(lfsr_bit),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  // LFSR core stand-in: Galois right shift, or step-count parity when par_mode is set.
  logic [LW-1:0] m_st = '0, m_tp = '0;
  int            m_n = 0;
  bit            par_mode = 1'b0;
  assign lfsr_bit = par_mode ? m_n[0] : m_st[0];

  always @(posedge ACLK) begin
    if (lfsr_load) begin
      m_st <= lfsr_seed;
      m_tp <= lfsr_taps;
      m_n  <= 0;
    end else if (lfsr_step) begin
      m_st <= (m_st >> 1) ^ (m_st[0] ? m_tp : '0);
      m_n  <= m_n + 1;
    end
  end

  // Monitor: per-cycle activity counts and accepted words.
  int            n_load, n_step, n_tv, n_irq;
  logic [OW-1:0] q_data[$];
  logic          q_last[$];

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (lfsr_load) n_load++;
      if (lfsr_step) n_step++;
      if (m_axis_tvalid) n_tv++;
      if (irq) n_irq++;
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
      end
    end
  end

  // Word w of a run is serial bits w*OW .. w*OW+OW-1 of the stream, first bit in the LSB.
  function automatic logic [OW-1:0] ref_word(input logic [LW-1:0] seed, input logic [LW-1:0] taps,
                                             input bit par, input int w);
    logic [LW-1:0] st;
    logic [OW-1:0] r;
    logic          b;
    st = seed;
    r  = '0;
    for (int i = 0; i < (w + 1) * OW; i++) begin
      b = par ? (i % 2 == 1) : st[0];
      if (i >= w * OW) r[i - w * OW] = b;
      st = {1'b0, st[LW-1:1]} ^ (st[0] ? taps : '0);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clr_mon();
    n_load = 0; n_step = 0; n_tv = 0; n_irq = 0;
    q_data.delete();
    q_last.delete();
  endtask

  task automatic do_start(input logic [LW-1:0] s, input logic [LW-1:0] t,
                          input logic [CW-1:0] w, input logic c);
    cfg_seed = s; cfg_taps = t; cfg_words = w; cfg_continuous = c;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int c;
    c = 0;
    while (m_axis_tvalid !== 1'b1 && c < budget) begin
      @(negedge ACLK);
      c++;
    end
    ok = (m_axis_tvalid === 1'b1);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c;
    c = 0;
    while (stat_busy !== 1'b0 && c < budget) begin
      @(negedge ACLK);
      c++;
    end
    ok = (stat_busy === 1'b0);
    repeat (3) @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) tick();
    @(negedge ACLK);
    checks++;
    if ({stat_busy, stat_done, stat_err, stat_words_sent, irq, lfsr_load, lfsr_seed, lfsr_taps,
         lfsr_step, m_axis_tdata, m_axis_tvalid, m_axis_tlast} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b err=%b ws=%0d tvalid=%b tdata=%h required all 0",
               stat_busy, stat_done, stat_err, stat_words_sent, m_axis_tvalid, m_axis_tdata);
    end
    tick();
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int c;
    bit ok;
    logic [OW-1:0] exp;
    par_mode = 1'b1;
    m_axis_tready = 1'b1;
    clr_mon();
    do_start(32'h1, 32'h8000_0057, 4'd2, 1'b0);
    @(negedge ACLK);
    checks++;
    if (lfsr_load !== 1'b1) begin
      errors++; $display("FAIL basic_load_cycle got %b required 1", lfsr_load);
    end
    c = 1;
    while (m_axis_tvalid !== 1'b1 && c < 60) begin
      @(negedge ACLK);
      c++;
    end
    checks++;
    if (c != OW + 2) begin
      errors++; $display("FAIL basic_tvalid_cycle got N+%0d required N+%0d", c, OW + 2);
    end
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_idle timeout busy=%b", stat_busy); end
    checks++;
    if (q_data.size() != 2) begin
      errors++; $display("FAIL basic_count got %0d required 2", q_data.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp = ref_word(32'h1, 32'h8000_0057, 1'b1, k);
        checks++;
        if (q_data[k] !== exp || q_last[k] !== (k == 1)) begin
          errors++;
          $display("FAIL basic_word%0d got %h/%b required %h/%b", k, q_data[k], q_last[k], exp, k == 1);
        end
      end
    end
    checks++;
    if ({stat_done, stat_err, stat_words_sent} !== {1'b1, 1'b0, 4'd2}) begin
      errors++; $display("FAIL basic_status got done=%b err=%b ws=%0d required 1 0 2",
                         stat_done, stat_err, stat_words_sent);
    end
    checks++;
    if (n_irq != IRQ_PER || n_step != 2 * OW || n_load != 1) begin
      errors++; $display("FAIL basic_activity got irq=%0d step=%0d load=%0d required %0d %0d 1",
                         n_irq, n_step, n_load, IRQ_PER, 2 * OW);
    end
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] s, t;
    logic [OW-1:0] d0, exp;
    logic          l0;
    bit            ok;
    tick();
    par_mode = 1'b0;
    s = $urandom | 32'h1;
    t = $urandom | 32'h8000_0000;
    m_axis_tready = 1'b0;
    clr_mon();
    do_start(s, t, 4'd3, 1'b0);
    wait_valid(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_valid timeout tvalid=%b", m_axis_tvalid); end
    d0 = m_axis_tdata;
    l0 = m_axis_tlast;
    repeat (10) begin
      @(negedge ACLK);
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, lfsr_step, m_axis_tdata} !== {1'b1, l0, 1'b0, d0}) begin
        errors++; $display("FAIL bp_hold got v=%b l=%b step=%b d=%h required 1 %b 0 %h",
                           m_axis_tvalid, m_axis_tlast, lfsr_step, m_axis_tdata, l0, d0);
      end
    end
    @(posedge ACLK);
    #1 m_axis_tready = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({lfsr_step, m_axis_tvalid} !== 2'b10) begin
      errors++; $display("FAIL bp_refill got step=%b tvalid=%b required 1 0", lfsr_step, m_axis_tvalid);
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || q_data.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d idle=%b required 3 1", q_data.size(), ok);
    end else begin
      for (int k = 0; k < 3; k++) begin
        exp = ref_word(s, t, 1'b0, k);
        checks++;
        if (q_data[k] !== exp || q_last[k] !== (k == 2)) begin
          errors++; $display("FAIL bp_word%0d got %h/%b required %h/%b", k, q_data[k], q_last[k], exp, k == 2);
        end
      end
    end
    checks++;
    if (stat_words_sent !== 4'd3 || n_step != 3 * OW) begin
      errors++; $display("FAIL bp_counts got ws=%0d step=%0d required 3 %0d", stat_words_sent, n_step, 3 * OW);
    end
  endtask

  task automatic test_cfg_err();
    bit ok;
    tick();
    clr_mon();
    do_start('0, $urandom, 4'd3, 1'b0);
    repeat (4) @(negedge ACLK);
    checks++;
    if ({stat_busy, stat_err, stat_done} !== 3'b011 || n_load != 0 || n_tv != 0 || n_irq != IRQ_PER) begin
      errors++; $display("FAIL err_seed0 got busy=%b err=%b done=%b load=%0d tv=%0d irq=%0d required 0 1 1 0 0 %0d",
                         stat_busy, stat_err, stat_done, n_load, n_tv, n_irq, IRQ_PER);
    end
    m_axis_tready = 1'b1;
    tick();
    do_start(32'h5, 32'hA300_0001, 4'd1, 1'b0);
    wait_idle(100, ok);
    checks++;
    if (!ok || {stat_err, stat_done} !== 2'b01) begin
      errors++; $display("FAIL err_cleared got err=%b done=%b idle=%b required 0 1 1", stat_err, stat_done, ok);
    end
    tick();
    clr_mon();
    do_start(32'h5, 32'hA300_0001, 4'd0, 1'b0);
    repeat (4) @(negedge ACLK);
    checks++;
    if ({stat_busy, stat_err, stat_done} !== 3'b011 || n_load != 0 || n_tv != 0 || n_irq != IRQ_PER) begin
      errors++; $display("FAIL err_words0 got busy=%b err=%b done=%b load=%0d tv=%0d irq=%0d required 0 1 1 0 0 %0d",
                         stat_busy, stat_err, stat_done, n_load, n_tv, n_irq, IRQ_PER);
    end
  endtask

  task automatic test_abort();
    logic [LW-1:0] s, t;
    logic [OW-1:0] d0, exp;
    bit            ok;
    tick();
    par_mode = 1'b0;
    s = $urandom | 32'h1;
    t = $urandom | 32'h8000_0000;
    m_axis_tready = 1'b1;
    clr_mon();
    do_start(s, t, 4'd4, 1'b0);
    @(negedge ACLK);
    checks++;
    if ({stat_busy, stat_err, stat_done} !== 3'b100) begin
      errors++; $display("FAIL abort_start_clear got busy=%b err=%b done=%b required 1 0 0",
                         stat_busy, stat_err, stat_done);
    end
    repeat (5) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({stat_busy, stat_done} !== 2'b01) begin
      errors++; $display("FAIL abort_fill got busy=%b done=%b required 0 1", stat_busy, stat_done);
    end
    repeat (3) @(negedge ACLK);
    checks++;
    if (n_tv != 0 || n_step != 5 || n_irq != IRQ_PER) begin
      errors++; $display("FAIL abort_fill_activity got tv=%0d step=%0d irq=%0d required 0 5 %0d",
                         n_tv, n_step, n_irq, IRQ_PER);
    end
    tick();
    s = $urandom | 32'h1;
    t = $urandom | 32'h8000_0000;
    m_axis_tready = 1'b0;
    clr_mon();
    do_start(s, t, 4'd3, 1'b0);
    wait_valid(100, ok);
    d0  = m_axis_tdata;
    exp = ref_word(s, t, 1'b0, 0);
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    @(negedge ACLK);
    checks++;
    if (!ok || {m_axis_tvalid, m_axis_tlast, stat_busy, m_axis_tdata} !== {3'b111, exp}) begin
      errors++; $display("FAIL abort_send_hold got v=%b l=%b busy=%b d=%h required 1 1 1 %h",
                         m_axis_tvalid, m_axis_tlast, stat_busy, m_axis_tdata, exp);
    end
    repeat (3) tick();
    m_axis_tready = 1'b1;
    wait_idle(50, ok);
    checks++;
    if (!ok || q_data.size() != 1 || q_data[0] !== d0 || q_last[0] !== 1'b1 ||
        {stat_done, stat_words_sent} !== {1'b1, 4'd1} || n_step != OW) begin
      errors++; $display("FAIL abort_send_end got n=%0d done=%b ws=%0d step=%0d required 1 1 1 %0d",
                         q_data.size(), stat_done, stat_words_sent, n_step, OW);
    end
  endtask

  task automatic test_continuous();
    logic [LW-1:0] s, t;
    logic [OW-1:0] exp;
    int            hs, c;
    bit            ok;
    tick();
    par_mode = 1'b0;
    s = $urandom | 32'h1;
    t = $urandom | 32'h8000_0000;
    clr_mon();
    do_start(s, t, 4'd3, 1'b1);
    hs = 0;
    c  = 0;
    while (hs < 17 && c < 3000) begin
      @(posedge ACLK);
      #1 m_axis_tready = ($urandom_range(0, 3) != 0);
      @(negedge ACLK);
      if (m_axis_tvalid && m_axis_tready) hs++;
      c++;
    end
    @(negedge ACLK);
    checks++;
    if (hs != 17 || stat_words_sent !== 4'd1) begin
      errors++; $display("FAIL cont_wrap got hs=%0d ws=%0d required 17 1", hs, stat_words_sent);
    end
    m_axis_tready = 1'b0;
    wait_valid(100, ok);
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    m_axis_tready = 1'b1;
    wait_idle(50, ok);
    checks++;
    if (!ok || q_data.size() != 18 || stat_words_sent !== 4'd2) begin
      errors++; $display("FAIL cont_count got n=%0d ws=%0d idle=%b required 18 2 1",
                         q_data.size(), stat_words_sent, ok);
    end
    for (int k = 0; k < q_data.size(); k++) begin
      exp = ref_word(s, t, 1'b0, k);
      checks++;
      if (q_data[k] !== exp || q_last[k] !== (k == 17)) begin
        errors++; $display("FAIL cont_word%0d got %h/%b required %h/%b", k, q_data[k], q_last[k], exp, k == 17);
      end
    end
  endtask

  task automatic test_reset_busy();
    logic [LW-1:0] s, t;
    logic [OW-1:0] exp;
    bit            ok;
    tick();
    par_mode = 1'b0;
    s = $urandom | 32'h1;
    t = $urandom | 32'h8000_0000;
    m_axis_tready = 1'b0;
    clr_mon();
    do_start(s, t, 4'd5, 1'b0);
    repeat (3) tick();
    cfg_seed  = s ^ 32'h1234_5678;
    cfg_taps  = ~t;
    cfg_words = 4'd1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_valid(100, ok);
    exp = ref_word(s, t, 1'b0, 0);
    checks++;
    if (!ok || lfsr_seed !== s || lfsr_taps !== t || m_axis_tdata !== exp || n_load != 1) begin
      errors++; $display("FAIL busy_start got seed=%h taps=%h d=%h load=%0d required %h %h %h 1",
                         lfsr_seed, lfsr_taps, m_axis_tdata, n_load, s, t, exp);
    end
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({stat_busy, stat_done, stat_err, stat_words_sent, irq, lfsr_load, lfsr_seed, lfsr_taps,
         lfsr_step, m_axis_tdata, m_axis_tvalid, m_axis_tlast} !== '0 || q_data.size() != 0) begin
      errors++; $display("FAIL reset_mid_send got busy=%b v=%b d=%h seed=%h n=%0d required all 0",
                         stat_busy, m_axis_tvalid, m_axis_tdata, lfsr_seed, q_data.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg_err();
    test_abort();
    test_continuous();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_lfsr_seq_ctrl.md
Name: m_lfsr_seq_ctrl

Overview:
Sequencer for the M-sequence LFSR datapath. It loads seed and taps into the LFSR, steps it one bit per cycle, and packs the serial bits into OUT_W-bit words. Words leave on an AXI4-Stream master port for a programmed word count, or continuously until aborted. The block sits between the AXI4-Lite register file (cfg/stat signals) and the LFSR core (lfsr_* signals).

Parameters:
LFSR_W, 32, width of LFSR state, seed and taps
OUT_W, 32, output word width; bits packed per word (>=2)
CNT_W, 32, width of word count and words-sent counter

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
cfg_start  in  1  one-cycle start pulse
cfg_abort  in  1  one-cycle abort pulse
cfg_continuous  in  1  1 = ignore cfg_words and run until abort
cfg_seed  in  LFSR_W  seed, sampled on accepted start
cfg_taps  in  LFSR_W  feedback taps, sampled on accepted start
cfg_words  in  CNT_W  words to emit, sampled on accepted start
stat_busy  out  1  high in any state other than IDLE
stat_done  out  1  sticky; set at run end, cleared by next accepted start
stat_err  out  1  sticky; set by a rejected config, cleared by next accepted start
stat_words_sent  out  CNT_W  handshakes completed in the current/last run
irq  out  1  one-cycle completion pulse
lfsr_load  out  1  load seed/taps into LFSR this cycle
lfsr_seed  out  LFSR_W  registered seed
lfsr_taps  out  LFSR_W  registered taps
lfsr_step  out  1  advance LFSR at the end of this cycle
lfsr_bit  in  1  current LFSR output bit (combinational from LFSR state)
m_axis_tdata  out  OUT_W  packed word; bit k = k-th bit stepped (LSB first)
m_axis_tvalid  out  1  word valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last word of run

Behaviour:
- Reset (ARESET=1 at an edge): state IDLE. All outputs 0, counters 0, sticky flags 0. Reset mid-run drops any pending word with no handshake.
- States: IDLE, LOAD, FILL, SEND.
- IDLE: cfg_start accepted only here; start while busy is ignored.
  - On accepted start, sample cfg_*.
  - If cfg_seed==0, or (cfg_words==0 and !cfg_continuous): set stat_err and stat_done, pulse irq, stay IDLE, no lfsr_load.
  - Otherwise clear done/err/words_sent and go to LOAD.
- LOAD: lfsr_load=1 for exactly one cycle, then FILL.
- FILL: lfsr_step=1 every cycle. Shift lfsr_bit into the packer at index bit_cnt. After OUT_W cycles go to SEND.
- SEND: tvalid=1; tdata and tlast stay stable until handshake (tvalid & tready); lfsr_step=0.
  - On handshake, words_sent increments.
  - tlast=1 when words_sent+1==cfg_words and not continuous.
  - After the handshake: if tlast, go IDLE, set done, pulse irq on the following cycle. Otherwise go to FILL (no reload).
- Timing: start sampled at edge N -> lfsr_load high in cycle N+1, lfsr_step high in cycles N+2..N+OUT_W+1, tvalid rises in cycle N+OUT_W+2. Steady state is OUT_W+1 cycles per word with tready held high.
- Abort:
  - In LOAD or FILL: go IDLE next cycle, set done, partial word discarded.
  - In SEND: hold the current word with tlast forced 1 until handshake, then IDLE and done. Abort during the handshake cycle itself takes the same path.
  - In IDLE: ignored.
  - Start and abort in the same IDLE cycle: abort wins, start ignored.
- Continuous mode: words_sent wraps 2^CNT_W-1 -> 0. tlast only via abort.
- cfg_* changes during a run have no effect.

Optional Feature:
M_LFSR_SEQ_CTRL_IRQ_EN
- Defined: irq pulses one cycle on every done/err set.
- Undefined: irq tied 0 and no irq logic is generated. stat_done/stat_err are unaffected.

Decomposition:
- Package m_lfsr_seq_ctrl_pkg holds:
  - state enum (IDLE, LOAD, FILL, SEND)
  - default width constants
  - function lsb_first_insert
- Sub-module m_lfsr_seq_packer holds the OUT_W shift register and bit counter. Interface: clear, shift_en, bit_in, full, word.

Test Plan:
- Basic run: seed=1, words=2; bench LFSR model outputs bit = step parity -> two words 0xAAAAAAAA, second has tlast=1; done=1, irq one pulse, words_sent=2; lfsr_load at N+1, tvalid at N+34.
- Backpressure: tready low 10 cycles in SEND -> tdata/tvalid/tlast stable, no lfsr_step, next FILL starts the cycle after handshake.
- Config error: seed=0 -> stat_err=1, done=1, no lfsr_load/tvalid. Separately words=0, continuous=0 gives the same response.
- Abort: abort in FILL cycle 5 -> IDLE next cycle, no tvalid. Abort in SEND with tready=0 -> word held with tlast=1, completes on tready, done=1.
- Continuous with CNT_W=4: 17 words emitted, none with tlast; words_sent reads 1 after wrap; abort ends with tlast.
- Reset mid-SEND and start while busy: ARESET=1 -> all outputs 0 next cycle. cfg_start in FILL -> ignored, cfg_seed change has no effect.
